// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: one I-mem read per cycle, next PC steered by the predictor,
// responses buffered with prediction metadata in a DEPTH-entry queue drained by decode.
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     INDEX_W  = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               globalResetN,
  input  logic               redirectValid,
  input  logic [XLEN-1:0]    redirectPC,
  output logic [XLEN-1:0]    fetchPC,
  input  logic               predTaken,
  input  logic [XLEN-1:0]    predTarget,
  input  logic [INDEX_W-1:0] predIndex,
  input  logic [1:0]         predState,
  output logic               imemReq,
  output logic [XLEN-1:0]    imemAddr,
  input  logic [XLEN-1:0]    imemData,
  output logic               deqValid,
  input  logic               deqReady,
  output logic [XLEN-1:0]    deqInstr,
  output logic [XLEN-1:0]    deqPC,
  output logic [XLEN-1:0]    deqPredPC,
  output logic               deqPredTaken,
  output logic [INDEX_W-1:0] deqGHRIndex,
  output logic [1:0]         deqPHTState,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pred_pc;
    logic               taken;
    logic [INDEX_W-1:0] index;
    logic [1:0]         state;
  } meta_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    meta_t           meta;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  meta_t           meta_q, meta_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  entry_t          queue_q [DEPTH];

  logic [CntW:0]   credit_used;
  logic [XLEN-1:0] next_pc;
  logic            issue, push, pop;
  entry_t          head;

  // Instructions are word aligned; the low redirect bits are dropped.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirectPC[1:0];

  // Credit check counts the in-flight read so its return always finds a free slot.
  assign credit_used = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign issue       = globalResetN && !redirectValid && (credit_used < (CntW+1)'(DEPTH));
  assign push        = inflight_q && !redirectValid;
  assign pop         = deqValid && deqReady;
  assign next_pc     = predTaken ? predTarget : fetch_pc_q + XLEN'(4);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    meta_d     = meta_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CntW'(push) - CntW'(pop);
    if (issue) begin
      fetch_pc_d = next_pc;
      meta_d     = '{pc: fetch_pc_q, pred_pc: next_pc, taken: predTaken,
                     index: predIndex, state: predState};
    end
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (redirectValid) begin
      fetch_pc_d = {redirectPC[XLEN-1:2], 2'b00};
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      meta_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      meta_q     <= meta_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: every output read from it is masked by deqValid.
  always_ff @(posedge clk) begin
    if (push) queue_q[wr_ptr_q] <= '{instr: imemData, meta: meta_q};
  end

  assign head         = queue_q[rd_ptr_q];
  assign deqValid     = (count_q != '0);
  assign deqInstr     = deqValid ? head.instr : '0;
  assign deqPC        = deqValid ? head.meta.pc : '0;
  assign deqPredPC    = deqValid ? head.meta.pred_pc : '0;
  assign deqPredTaken = deqValid && head.meta.taken;
  assign deqGHRIndex  = deqValid ? head.meta.index : '0;
  assign deqPHTState  = deqValid ? head.meta.state : '0;
  assign occupancy    = count_q;
  assign fetchPC      = fetch_pc_q;
  assign imemAddr     = fetch_pc_q;
  assign imemReq      = issue;

endmodule
